// File: rtl/radix6_bfly_sched_if.sv
// Stream interface for the radix-6 butterfly sequencer: one sample-in channel
// and one result-out channel, each with a valid/ready handshake.
interface radix6_bfly_sched_if #(
    parameter int unsigned DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_img;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_img;
    logic [2:0]    out_idx;
    logic          out_last;

    // Sequencer side: consumes samples, produces results.
    modport slave (
        input  in_valid, in_re, in_img, out_ready,
        output in_ready, out_valid, out_re, out_img, out_idx, out_last
    );

    // Upstream/downstream side: produces samples, consumes results.
    modport master (
        output in_valid, in_re, in_img, out_ready,
        input  in_ready, out_valid, out_re, out_img, out_idx, out_last
    );
endinterface

// File: rtl/radix6_bfly_sched.sv
// Radix-6 butterfly sequencer.
// Gathers six complex samples into the butterfly input registers, holds them
// for the butterfly latency, captures the six results and drains them one
// per handshake. Words pass through bit-exact; no arithmetic here.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_COLLECT | accepting samples 0..5 into bf_a..bf_f
//   ST_WAIT    | inputs stable; down-counting the butterfly latency
//   ST_DRAIN   | presenting buffered results ao..fo on the output stream
module radix6_bfly_sched #(
    parameter int unsigned BF_LAT = 2,
    parameter int unsigned DW     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 soft_clr,
    radix6_bfly_sched_if.slave   io,
    output logic [DW-1:0]        bf_a_re,
    output logic [DW-1:0]        bf_a_img,
    output logic [DW-1:0]        bf_b_re,
    output logic [DW-1:0]        bf_b_img,
    output logic [DW-1:0]        bf_c_re,
    output logic [DW-1:0]        bf_c_img,
    output logic [DW-1:0]        bf_d_re,
    output logic [DW-1:0]        bf_d_img,
    output logic [DW-1:0]        bf_e_re,
    output logic [DW-1:0]        bf_e_img,
    output logic [DW-1:0]        bf_f_re,
    output logic [DW-1:0]        bf_f_img,
    input  logic [DW-1:0]        bf_ao_re,
    input  logic [DW-1:0]        bf_ao_img,
    input  logic [DW-1:0]        bf_bo_re,
    input  logic [DW-1:0]        bf_bo_img,
    input  logic [DW-1:0]        bf_co_re,
    input  logic [DW-1:0]        bf_co_img,
    input  logic [DW-1:0]        bf_do_re,
    input  logic [DW-1:0]        bf_do_img,
    input  logic [DW-1:0]        bf_eo_re,
    input  logic [DW-1:0]        bf_eo_img,
    input  logic [DW-1:0]        bf_fo_re,
    input  logic [DW-1:0]        bf_fo_img,
    output logic                 busy,
    output logic [15:0]          group_cnt
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(BF_LAT);

    state_t        state_q, state_d;
    logic [2:0]    k_q, k_d;
    logic [3:0]    wait_q, wait_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   group_cnt_q;
    logic          accept, capture;
    logic          in_ready_c, out_valid_c;

    logic [DW-1:0] in_re_q  [6];
    logic [DW-1:0] in_img_q [6];
    logic [DW-1:0] res_re_q [6];
    logic [DW-1:0] res_img_q[6];
    logic [DW-1:0] bfo_re   [6];
    logic [DW-1:0] bfo_img  [6];

    assign bfo_re  = '{bf_ao_re,  bf_bo_re,  bf_co_re,  bf_do_re,  bf_eo_re,  bf_fo_re};
    assign bfo_img = '{bf_ao_img, bf_bo_img, bf_co_img, bf_do_img, bf_eo_img, bf_fo_img};

    // Next-state and handshake decode; soft_clr overrides everything last.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wait_d      = wait_q;
        idx_d       = idx_q;
        accept      = 1'b0;
        capture     = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                in_ready_c = 1'b1;
                if (io.in_valid) begin
                    accept = 1'b1;
                    if (k_q == 3'd5) begin
                        k_d     = 3'd0;
                        wait_d  = LAT_INIT;
                        state_d = ST_WAIT;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    capture = 1'b1;
                    idx_d   = 3'd0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid_c = 1'b1;
                if (io.out_ready) begin
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        state_d = ST_COLLECT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
        if (soft_clr) begin
            state_d    = ST_COLLECT;
            k_d        = 3'd0;
            wait_d     = 4'd0;
            idx_d      = 3'd0;
            accept     = 1'b0;
            capture    = 1'b0;
            in_ready_c = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            k_q     <= 3'd0;
            wait_q  <= 4'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
        end
    end

    // Butterfly input registers; only written on an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                in_re_q[i]  <= '0;
                in_img_q[i] <= '0;
            end
        end else if (accept) begin
            in_re_q[k_q]  <= io.in_re;
            in_img_q[k_q] <= io.in_img;
        end
    end

    // Result buffer and completed-group counter, updated on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                res_re_q[i]  <= '0;
                res_img_q[i] <= '0;
            end
            group_cnt_q <= 16'd0;
        end else if (capture) begin
            for (int i = 0; i < 6; i++) begin
                res_re_q[i]  <= bfo_re[i];
                res_img_q[i] <= bfo_img[i];
            end
            group_cnt_q <= group_cnt_q + 16'd1;
        end
    end

    assign bf_a_re  = in_re_q[0];
    assign bf_a_img = in_img_q[0];
    assign bf_b_re  = in_re_q[1];
    assign bf_b_img = in_img_q[1];
    assign bf_c_re  = in_re_q[2];
    assign bf_c_img = in_img_q[2];
    assign bf_d_re  = in_re_q[3];
    assign bf_d_img = in_img_q[3];
    assign bf_e_re  = in_re_q[4];
    assign bf_e_img = in_img_q[4];
    assign bf_f_re  = in_re_q[5];
    assign bf_f_img = in_img_q[5];

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = out_valid_c;
    assign io.out_re    = res_re_q[idx_q];
    assign io.out_img   = res_img_q[idx_q];
    assign io.out_idx   = idx_q;
    assign io.out_last  = (idx_q == 3'd5);

    assign busy      = (state_q != ST_COLLECT) || (k_q != 3'd0);
    assign group_cnt = group_cnt_q;

endmodule

// File: tb/tb_radix6_bfly_sched.sv
// Bench for radix6_bfly_sched: a 2-cycle stub butterfly (dut_a) and a
// combinational pass-through stub (dut_b). Expected results are queued when
// a group is fed and compared as each result is handed off downstream.
module tb_radix6_bfly_sched;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic soft_clr_a = 1'b0;
    logic soft_clr_b = 1'b0;
    logic busy_a, busy_b;
    logic [15:0] gcnt_a, gcnt_b;

    radix6_bfly_sched_if #(.DW(DW)) ia ();
    radix6_bfly_sched_if #(.DW(DW)) ib ();

    logic [31:0] a_bf_re [6];
    logic [31:0] a_bf_im [6];
    logic [31:0] p1_re   [6];
    logic [31:0] p1_im   [6];
    logic [31:0] a_res_re[6];
    logic [31:0] a_res_im[6];
    logic [31:0] b_bf_re [6];
    logic [31:0] b_bf_im [6];

    logic [31:0] g_re[6];
    logic [31:0] g_im[6];
    logic [31:0] qa_re[$];
    logic [31:0] qa_im[$];
    logic [2:0]  qa_idx[$];
    logic [31:0] qb_re[$];
    logic [31:0] qb_im[$];
    logic [2:0]  qb_idx[$];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    radix6_bfly_sched #(.BF_LAT(2), .DW(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr_a), .io(ia),
        .bf_a_re(a_bf_re[0]), .bf_a_img(a_bf_im[0]), .bf_b_re(a_bf_re[1]), .bf_b_img(a_bf_im[1]),
        .bf_c_re(a_bf_re[2]), .bf_c_img(a_bf_im[2]), .bf_d_re(a_bf_re[3]), .bf_d_img(a_bf_im[3]),
        .bf_e_re(a_bf_re[4]), .bf_e_img(a_bf_im[4]), .bf_f_re(a_bf_re[5]), .bf_f_img(a_bf_im[5]),
        .bf_ao_re(a_res_re[0]), .bf_ao_img(a_res_im[0]), .bf_bo_re(a_res_re[1]), .bf_bo_img(a_res_im[1]),
        .bf_co_re(a_res_re[2]), .bf_co_img(a_res_im[2]), .bf_do_re(a_res_re[3]), .bf_do_img(a_res_im[3]),
        .bf_eo_re(a_res_re[4]), .bf_eo_img(a_res_im[4]), .bf_fo_re(a_res_re[5]), .bf_fo_img(a_res_im[5]),
        .busy(busy_a), .group_cnt(gcnt_a)
    );

    radix6_bfly_sched #(.BF_LAT(0), .DW(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr_b), .io(ib),
        .bf_a_re(b_bf_re[0]), .bf_a_img(b_bf_im[0]), .bf_b_re(b_bf_re[1]), .bf_b_img(b_bf_im[1]),
        .bf_c_re(b_bf_re[2]), .bf_c_img(b_bf_im[2]), .bf_d_re(b_bf_re[3]), .bf_d_img(b_bf_im[3]),
        .bf_e_re(b_bf_re[4]), .bf_e_img(b_bf_im[4]), .bf_f_re(b_bf_re[5]), .bf_f_img(b_bf_im[5]),
        .bf_ao_re(b_bf_re[0]), .bf_ao_img(b_bf_im[0]), .bf_bo_re(b_bf_re[1]), .bf_bo_img(b_bf_im[1]),
        .bf_co_re(b_bf_re[2]), .bf_co_img(b_bf_im[2]), .bf_do_re(b_bf_re[3]), .bf_do_img(b_bf_im[3]),
        .bf_eo_re(b_bf_re[4]), .bf_eo_img(b_bf_im[4]), .bf_fo_re(b_bf_re[5]), .bf_fo_img(b_bf_im[5]),
        .busy(busy_b), .group_cnt(gcnt_b)
    );

    // Stub butterfly: every output depends on its own input and on sample f.
    function automatic logic [31:0] mix_re(input int i, input logic [31:0] r, input logic [31:0] f);
        return r + f + 32'(i);
    endfunction

    function automatic logic [31:0] mix_im(input int i, input logic [31:0] r, input logic [31:0] f);
        return r ^ {f[15:0], f[31:16]} ^ 32'(i * 3);
    endfunction

    // Two-stage pipelined stub butterfly for dut_a.
    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            p1_re[i]    <= mix_re(i, a_bf_re[i], a_bf_im[5]);
            p1_im[i]    <= mix_im(i, a_bf_im[i], a_bf_re[5]);
            a_res_re[i] <= p1_re[i];
            a_res_im[i] <= p1_im[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int qsize(input bit u);
        return u ? qb_re.size() : qa_re.size();
    endfunction

    // Scoreboard for dut_a: compare on each accepted result transfer.
    always @(negedge clk) begin
        if (rst_n && ia.out_valid && ia.out_ready && !soft_clr_a) begin
            if (qa_re.size() == 0) begin
                chk("a_sb_nonempty", 32'(qa_re.size()), 32'd1);
            end else begin
                logic [31:0] er, ei;
                logic [2:0]  ex;
                er = qa_re.pop_front();
                ei = qa_im.pop_front();
                ex = qa_idx.pop_front();
                chk("a_out_re", ia.out_re, er);
                chk("a_out_img", ia.out_img, ei);
                chk("a_out_idx", 32'(ia.out_idx), 32'(ex));
                chk("a_out_last", 32'(ia.out_last), 32'(ex == 3'd5));
            end
        end
    end

    // Scoreboard for dut_b.
    always @(negedge clk) begin
        if (rst_n && ib.out_valid && ib.out_ready && !soft_clr_b) begin
            if (qb_re.size() == 0) begin
                chk("b_sb_nonempty", 32'(qb_re.size()), 32'd1);
            end else begin
                logic [31:0] er, ei;
                logic [2:0]  ex;
                er = qb_re.pop_front();
                ei = qb_im.pop_front();
                ex = qb_idx.pop_front();
                chk("b_out_re", ib.out_re, er);
                chk("b_out_img", ib.out_img, ei);
                chk("b_out_idx", 32'(ib.out_idx), 32'(ex));
                chk("b_out_last", 32'(ib.out_last), 32'(ex == 3'd5));
            end
        end
    end

    task automatic send(input bit u, input logic [31:0] re, input logic [31:0] im);
        bit ok;
        ok = 1'b0;
        if (u) begin ib.in_valid = 1'b1; ib.in_re = re; ib.in_img = im; end
        else   begin ia.in_valid = 1'b1; ia.in_re = re; ia.in_img = im; end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (u ? ib.in_ready : ia.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (u) ib.in_valid = 1'b0; else ia.in_valid = 1'b0;
    endtask

    task automatic rand_group();
        for (int i = 0; i < 6; i++) begin
            g_re[i] = $urandom;
            g_im[i] = $urandom;
        end
    endtask

    // Feed the six samples in g_*, then queue the model results.
    task automatic feed(input bit u, input bit gap);
        for (int i = 0; i < 6; i++) begin
            send(u, g_re[i], g_im[i]);
            if (gap && i < 5) begin
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (u) begin
                qb_re.push_back(g_re[i]);
                qb_im.push_back(g_im[i]);
                qb_idx.push_back(3'(i));
            end else begin
                qa_re.push_back(mix_re(i, g_re[i], g_im[5]));
                qa_im.push_back(mix_im(i, g_im[i], g_re[5]));
                qa_idx.push_back(3'(i));
            end
        end
    endtask

    task automatic check_bf(input bit u);
        for (int i = 0; i < 6; i++) begin
            chk("bf_in_re", u ? b_bf_re[i] : a_bf_re[i], g_re[i]);
            chk("bf_in_img", u ? b_bf_im[i] : a_bf_im[i], g_im[i]);
        end
    endtask

    // Count rising edges from the 6th accept until out_valid appears.
    task automatic check_lat(input bit u, input int exp_edges);
        int k;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (u ? ib.out_valid : ia.out_valid) break;
            chk("wait_in_ready", 32'(u ? ib.in_ready : ia.in_ready), 32'd0);
        end
        chk("capture_edge", 32'(k - 1), 32'(exp_edges));
    endtask

    task automatic wait_drain(input bit u);
        for (int t = 0; t < 200; t++) begin
            if (qsize(u) == 0) break;
            @(negedge clk);
        end
        chk("drain_done", 32'(qsize(u)), 32'd0);
        @(negedge clk);
        chk("post_in_ready", 32'(u ? ib.in_ready : ia.in_ready), 32'd1);
        chk("post_out_valid", 32'(u ? ib.out_valid : ia.out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ia.in_valid = 1'b0; ia.in_re = '0; ia.in_img = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_re = '0; ib.in_img = '0; ib.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
        chk("rst_gcnt", 32'(gcnt_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_bf_a_re", a_bf_re[0], 32'd0);
        chk("rst_out_re", ia.out_re, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed group, BF_LAT=2, out_ready held high.
        g_re = '{32'h3f491a30, 32'h3f15c290, 32'hc14c0000, 32'hc1361234, 32'hc0341a18, 32'hbf15c290};
        g_im = '{32'h4246570a, 32'hc14c0000, 32'h4246570a, 32'h42acd70a, 32'h42a5ed71, 32'h4246570a};
        feed(1'b0, 1'b0);
        check_bf(1'b0);
        check_lat(1'b0, 3);
        wait_drain(1'b0);
        chk("gcnt_after_1", 32'(gcnt_a), 32'd1);

        // Upstream gaps and a 4-cycle downstream stall at idx 2.
        rand_group();
        feed(1'b0, 1'b1);
        check_bf(1'b0);
        check_lat(1'b0, 3);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (ia.out_valid && ia.out_idx == 3'd2) break;
        end
        ia.out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stall_idx", 32'(ia.out_idx), 32'd2);
            chk("stall_re", ia.out_re, qa_re[0]);
            chk("stall_img", ia.out_img, qa_im[0]);
            chk("stall_in_ready", 32'(ia.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 ia.out_ready = 1'b1;
        wait_drain(1'b0);
        chk("gcnt_after_2", 32'(gcnt_a), 32'd2);

        // BF_LAT=0 with pass-through butterfly.
        rand_group();
        feed(1'b1, 1'b0);
        check_bf(1'b1);
        check_lat(1'b1, 1);
        wait_drain(1'b1);
        chk("b_gcnt", 32'(gcnt_b), 32'd1);

        // soft_clr after three samples; a sample offered with it is refused.
        rand_group();
        for (int i = 0; i < 3; i++) send(1'b0, g_re[i], g_im[i]);
        soft_clr_a = 1'b1;
        ia.in_valid = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 32'(ia.in_ready), 32'd0);
        @(posedge clk);
        #1;
        soft_clr_a = 1'b0;
        ia.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_busy", 32'(busy_a), 32'd0);
        chk("clr_gcnt", 32'(gcnt_a), 32'd2);
        @(posedge clk);
        #1;
        rand_group();
        feed(1'b0, 1'b0);
        check_bf(1'b0);
        check_lat(1'b0, 3);
        wait_drain(1'b0);
        chk("gcnt_after_clr", 32'(gcnt_a), 32'd3);

        // soft_clr during DRAIN at idx 3.
        rand_group();
        feed(1'b0, 1'b0);
        check_lat(1'b0, 3);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (ia.out_valid && ia.out_idx == 3'd3) break;
        end
        soft_clr_a = 1'b1;
        @(posedge clk);
        #1 soft_clr_a = 1'b0;
        @(negedge clk);
        chk("dclr_out_valid", 32'(ia.out_valid), 32'd0);
        chk("dclr_in_ready", 32'(ia.in_ready), 32'd1);
        chk("dclr_q_left", 32'(qa_re.size()), 32'd3);
        chk("dclr_gcnt", 32'(gcnt_a), 32'd4);
        qa_re.delete(); qa_im.delete(); qa_idx.delete();
        @(posedge clk);
        #1;

        // Asynchronous reset pulse in the middle of WAIT.
        rand_group();
        feed(1'b0, 1'b0);
        chk("pre_rst_in_ready", 32'(ia.in_ready), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("arst_gcnt", 32'(gcnt_a), 32'd0);
        chk("arst_in_ready", 32'(ia.in_ready), 32'd1);
        chk("arst_busy", 32'(busy_a), 32'd0);
        qa_re.delete(); qa_im.delete(); qa_idx.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counter wrap: preload 0xFFFF, run one more group.
        force dut_a.group_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.group_cnt_q;
        @(negedge clk);
        chk("preload_gcnt", 32'(gcnt_a), 32'h0000FFFF);
        @(posedge clk);
        #1;
        rand_group();
        feed(1'b0, 1'b0);
        check_lat(1'b0, 3);
        wait_drain(1'b0);
        chk("wrap_gcnt", 32'(gcnt_a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/radix6_bfly_sched.md
Name: radix6_bfly_sched

Overview:
- Sequencer that feeds the radix-6 butterfly datapath (radix_6_top) from a serial complex-sample stream.
- Collects six IEEE-754 single-precision complex samples into an input group and holds them stable on the butterfly inputs for the butterfly latency.
- Captures the six results and drains them serially with a valid/ready handshake.
- Sits between the upstream sample source and downstream FFT stage logic; instantiated beside radix_6_top.

Parameters:
- BF_LAT, 2, butterfly input-to-output latency in clk cycles (0 = combinational); legal range 0..15.
- DW, 32, width of each real/imaginary word (IEEE-754 single).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- soft_clr  input  1  synchronous abort; discards partial or in-flight group
- in_valid  input  1  upstream sample valid
- in_ready  output  1  block accepts a sample this cycle
- in_re, in_img  input  DW each  upstream sample real/imag
- bf_{a,b,c,d,e,f}_re, bf_{a..f}_img  output  DW each  butterfly inputs
- bf_{ao,bo,co,do,eo,fo}_re, bf_{ao..fo}_img  input  DW each  butterfly results
- out_valid  output  1  result sample valid
- out_ready  input  1  downstream accepts
- out_re, out_img  output  DW each  result sample
- out_idx  output  3  result index 0..5 (0 = ao, 5 = fo)
- out_last  output  1  high with out_idx==5
- busy  output  1  high whenever state is not COLLECT or the sample count is not 0
- group_cnt  output  16  completed groups captured, wraps

Behaviour:
- Reset (rst_n low, async): state=COLLECT, sample count=0, wait count=0, out index=0, all bf_* inputs registers=0, result buffer=0, out_valid=0, in_ready=1 (combinational from state), group_cnt=0, busy=0.
- States: COLLECT, WAIT, DRAIN.
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready, sample k (k=0..5) is written to butterfly input register a..f respectively; k increments.
  - On acceptance of k=5: k->0, state->WAIT, wait count loaded with BF_LAT.
- bf_* outputs are driven directly from the input registers; they change only on accepts in COLLECT, so they are stable throughout WAIT.
- WAIT:
  - in_ready=0.
  - Each cycle, if wait count!=0, decrement it.
  - When wait count==0: capture all 12 bf_*o words into the result buffer, increment group_cnt (0xFFFF->0x0000), state->DRAIN, out index=0.
  - Capture edge is the (BF_LAT+1)th rising edge after the edge that registered sample 5.
- DRAIN:
  - out_valid=1; out_re/out_img = buffered result[out index]; out_idx = out index; out_last = (out index==5).
  - Data is held stable while out_ready=0.
  - On out_valid&&out_ready: index increments; on index 5 accepted, state->COLLECT, out_valid=0, in_ready=1 from the next cycle.
- No overlap: no new sample is accepted until the drain completes. Throughput is one group per 6+BF_LAT+1+6 cycles minimum.
- soft_clr:
  - Highest priority: next state is COLLECT with k=0, wait count=0, out_valid=0, index=0.
  - Any accept or capture in the same cycle is ignored.
  - group_cnt is unchanged; bf_* registers are not cleared.
- An in_valid arriving while soft_clr=1 is not accepted (in_ready forced 0 that cycle).
- rst_n asserted mid-group: immediate async return to reset values; the partial group is lost.
- No arithmetic is performed in this block; words pass bit-exact.

Test Plan:
- Single group, BF_LAT=2, out_ready=1:
  - Stimulus: feed re/img pairs (3f491a30,4246570a),(3f15c290,c14c0000),(c14c0000,4246570a),(c1361234,42acd70a),(c0341a18,42a5ed71),(bf15c290,4246570a).
  - Required response: bf_a..f registers match in order; capture 3 edges after the 6th accept; 6 outputs equal to the model butterfly results, out_idx 0..5, out_last on idx 5; group_cnt=1.
- Upstream gaps and downstream backpressure:
  - Stimulus: in_valid toggled every other cycle; out_ready low for 4 cycles at idx 2.
  - Required response: out data and idx held stable through the stall; no sample dropped; in_ready=0 throughout WAIT/DRAIN.
- BF_LAT=0 (combinational stub butterfly: ao=a etc.):
  - Required response: capture on the first edge after the 6th accept; outputs equal the inputs.
- soft_clr after 3 samples accepted:
  - Required response: k returns to 0; the next 6 samples form a clean group; group_cnt not incremented by the aborted group. Repeat with soft_clr during DRAIN at idx 3: out_valid drops next cycle.
- Async rst_n pulse mid-WAIT (not aligned to clk):
  - Required response: out_valid=0, group_cnt=0, in_ready=1 immediately.
- Preload 65535 completed groups (or force the counter), then run one more:
  - Required response: group_cnt wraps to 0x0000.
